rgbw_serial_rx: RTL

SK6812RGBW single-wire serial decoder. It is the receive end of the waveform that rgb_sotp transmits.
- Measures high-pulse widths on the incoming line and resolves each pulse to a bit.
- Assembles bits MSB-first into 32-bit GRBW words.
- Pushes each complete word into the write port of async_fifo.
- Detects the long-low latch/reset gap as end of frame.
- Used for loopback checking of the LED output path and for chaining upstream LED streams into the FPGA.

---
 rtl/rgbw_serial_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rgbw_serial_rx.sv
// rgbw_serial_rx: SK6812RGBW single-wire decoder that feeds the write port of an async FIFO.
// Define RGBW_RX_GLITCH_CHECK_EN to flag and drop words that contain a too-short high pulse.
module rgbw_serial_rx #(
    parameter int DATA_SIZE       = 32,
    parameter int RGBW_BIT_THRESH = 3,
    parameter int RGBW_MIN_HIGH   = 2,
    parameter int RGBW_STR_RST    = 20,
    parameter int COUNTER_MAX     = 7800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_sig,
    input  logic                 in_wr_fifo_full,
    output logic                 out_wr_fifo_en,
    output logic [DATA_SIZE-1:0] out_wr_fifo_data,
    output logic                 out_frame_done,
    output logic                 out_err_overflow,
    output logic                 out_err_glitch
);
    localparam int CW = $clog2(COUNTER_MAX + 1);
    localparam int BW = $clog2(DATA_SIZE);

    localparam logic [CW-1:0] CNT_MAX    = CW'(COUNTER_MAX);
    localparam logic [CW-1:0] BIT_THRESH = CW'(RGBW_BIT_THRESH);
    localparam logic [CW-1:0] STR_RST    = CW'(RGBW_STR_RST);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_SIZE - 1);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    // A minimum at or above the 1-threshold would turn every legal 0 bit into a glitch.
    if (RGBW_MIN_HIGH >= RGBW_BIT_THRESH) begin : g_bad_min_high
        $error("RGBW_MIN_HIGH must be below RGBW_BIT_THRESH");
    end

    logic [1:0]           state;
    logic                 sync1;
    logic                 s_sig;
    logic                 sig_d;
    logic                 rise;
    logic                 fall;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_SIZE-2:0] shift;
    logic                 bit_val;
    logic [DATA_SIZE-1:0] word;

    assign rise    = s_sig & ~sig_d;
    assign fall    = ~s_sig & sig_d;
    assign bit_val = (cnt >= BIT_THRESH);
    // Only DATA_SIZE-1 bits are stored; the deciding bit joins them on the completing edge.
    assign word    = {shift, bit_val};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            s_sig <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sync1 <= in_sig;
            s_sig <= sync1;
            sig_d <= s_sig;
        end
    end

    // Restarts at 1 on an edge, so cnt is the number of clocks the current level has lasted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= CW'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef RGBW_RX_GLITCH_CHECK_EN
    localparam logic [CW-1:0] MIN_HIGH = CW'(RGBW_MIN_HIGH);
`else
    assign out_err_glitch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= ST_SYNC;
            bit_cnt          <= '0;
            shift            <= '0;
            out_wr_fifo_en   <= 1'b0;
            out_wr_fifo_data <= '0;
            out_frame_done   <= 1'b0;
            out_err_overflow <= 1'b0;
`ifdef RGBW_RX_GLITCH_CHECK_EN
            out_err_glitch   <= 1'b0;
`endif
        end else begin
            out_wr_fifo_en <= 1'b0;
            out_frame_done <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (!s_sig && !fall && cnt >= STR_RST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
`ifdef RGBW_RX_GLITCH_CHECK_EN
                        if (cnt < MIN_HIGH) begin
                            out_err_glitch <= 1'b1;
                            bit_cnt        <= '0;
                            state          <= ST_SYNC;
                        end else
`endif
                        begin
                            shift <= word[DATA_SIZE-2:0];
                            state <= ST_LOW;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                if (in_wr_fifo_full) begin
                                    out_err_overflow <= 1'b1;
                                end else begin
                                    out_wr_fifo_en   <= 1'b1;
                                    out_wr_fifo_data <= word;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (rise) begin
                        state <= ST_HIGH;
                    end else if (cnt >= STR_RST) begin
                        out_frame_done <= 1'b1;
                        bit_cnt        <= '0;
                        state          <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
